// File: rtl/snake_pkg.sv
// Shared direction encoding for the snake game: 2-bit direction type, named
// directions and the opposite-direction helper. Opposites differ only in bit 0.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_PART  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small turn queue: DEPTH entries of 2-bit direction, head and tail visible
// combinationally. A push into a full queue succeeds only alongside a pop.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  dir_t       wdata,
  output dir_t       head,
  output dir_t       tail,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dir_t          mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tail_ptr;
  logic [2:0]    cnt_q, cnt_d;
  occ_t          occ_q, occ_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= OCC_EMPTY;
      cnt_q    <= 3'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    do_pop   = pop && (occ_q != OCC_EMPTY);
    do_push  = push && ((occ_q != OCC_FULL) || do_pop);
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    if (cnt_d == 3'd0)              occ_d = OCC_EMPTY;
    else if (cnt_d == 3'(DEPTH))    occ_d = OCC_FULL;
    else                            occ_d = OCC_PART;
  end

  always_comb begin
    full     = (occ_q == OCC_FULL);
    empty    = (occ_q == OCC_EMPTY);
    count    = cnt_q;
    tail_ptr = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - PW'(1);
    head     = mem_q[rd_ptr_q];
    tail     = mem_q[tail_ptr];
  end

endmodule

// File: rtl/key_dir_ctrl.sv
// Snake direction controller: resolves key pulses by priority, rejects
// non-turns against the last queued direction, and applies one turn per step.
module key_dir_ctrl
  import snake_pkg::*;
#(
  parameter int   DEPTH    = 2,
  parameter dir_t INIT_DIR = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       step_req,
  output dir_t       dir,
  output logic       dir_chg,
  output logic       key_drop,
  output logic [2:0] pend_cnt
);

  dir_t       dir_q, dir_d;
  logic       dir_chg_q, dir_chg_d;
  logic       key_drop_q, key_drop_d;
  logic [3:0] keys;
  logic       win_vld, multi, is_turn, push, pop;
  dir_t       win, ref_dir, head, tail;
  logic       full, empty;
  logic [2:0] count;

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (win),
    .head  (head),
    .tail  (tail),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    keys    = {key_up, key_down, key_left, key_right};
    win_vld = |keys;
    multi   = (keys & (keys - 4'd1)) != 4'd0;
    if (key_up)        win = DIR_UP;
    else if (key_down) win = DIR_DOWN;
    else if (key_left) win = DIR_LEFT;
    else               win = DIR_RIGHT;
    // Compare against the newest pending turn, using pre-pop queue contents.
    ref_dir    = empty ? dir_q : tail;
    is_turn    = (win != ref_dir) && (win != opposite(ref_dir));
    pop        = step_req && !empty;
    push       = win_vld && is_turn && (!full || pop);
    dir_d      = pop ? head : dir_q;
    dir_chg_d  = pop;
    key_drop_d = multi || (win_vld && !is_turn) || (win_vld && is_turn && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= INIT_DIR;
      dir_chg_q  <= 1'b0;
      key_drop_q <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      dir_chg_q  <= dir_chg_d;
      key_drop_q <= key_drop_d;
    end
  end

  assign dir      = dir_q;
  assign dir_chg  = dir_chg_q;
  assign key_drop = key_drop_q;
  assign pend_cnt = count;

endmodule

// File: tb/tb_key_dir_ctrl.sv
// Bench for key_dir_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the turn rules.
module tb_key_dir_ctrl;

  localparam int DEPTH = 2;
  localparam logic [3:0] K_NONE = 4'b0000, K_UP = 4'b1000, K_DN = 4'b0100,
                         K_LT = 4'b0010, K_RT = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       step_req = 1'b0;
  logic [1:0] dir;
  logic       dir_chg, key_drop;
  logic [2:0] pend_cnt;

  int total = 0;
  int passed = 0;

  logic [1:0] mq[$];
  logic [1:0] mdir = 2'd3;
  logic       mchg = 1'b0;
  logic       mdrop = 1'b0;

  key_dir_ctrl #(.DEPTH(DEPTH), .INIT_DIR(2'd3)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right), .step_req(step_req),
    .dir(dir), .dir_chg(dir_chg), .key_drop(key_drop), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic [3:0] k, input logic s);
    int n;
    logic [1:0] win, refd;
    bit push, pop;
    if (r) begin
      mq.delete(); mdir = 2'd3; mchg = 1'b0; mdrop = 1'b0;
      return;
    end
    n = $countones(k);
    win = k[3] ? 2'd0 : k[2] ? 2'd1 : k[1] ? 2'd2 : 2'd3;
    refd = (mq.size() > 0) ? mq[$] : mdir;
    pop = s && (mq.size() > 0);
    push = 1'b0;
    mdrop = (n > 1);
    if (n > 0) begin
      if (win == refd || win == (refd ^ 2'b01)) mdrop = 1'b1;
      else if (mq.size() == DEPTH && !pop)     mdrop = 1'b1;
      else                                     push = 1'b1;
    end
    mchg = pop;
    if (pop) mdir = mq.pop_front();
    if (push) mq.push_back(win);
  endtask

  task automatic tick(input logic r, input logic [3:0] k, input logic s);
    rst = r;
    {key_up, key_down, key_left, key_right} = k;
    step_req = s;
    model_step(r, k, s);
    @(posedge clk);
    #1;
    rst = 1'b0;
    {key_up, key_down, key_left, key_right} = 4'b0000;
    step_req = 1'b0;
  endtask

  task automatic test_reset;
    tick(1'b1, 4'b1111, 1'b1);
    total++; if (dir !== 2'd3) $display("FAIL reset_dir got=%0d exp=3", dir); else passed++;
    total++; if (dir_chg !== 1'b0) $display("FAIL reset_chg got=%b exp=0", dir_chg); else passed++;
    total++; if (key_drop !== 1'b0) $display("FAIL reset_drop got=%b exp=0", key_drop); else passed++;
    total++; if (pend_cnt !== 3'd0) $display("FAIL reset_cnt got=%0d exp=0", pend_cnt); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, K_NONE, 1'b1);
      total++;
      if (dir !== 2'd3 || dir_chg !== 1'b0 || pend_cnt !== 3'd0)
        $display("FAIL empty_step%0d got dir=%0d chg=%b cnt=%0d exp dir=3 chg=0 cnt=0", i, dir, dir_chg, pend_cnt);
      else passed++;
    end
  endtask

  task automatic test_single_turn;
    tick(1'b1, K_NONE, 1'b0);
    tick(1'b0, K_UP, 1'b0);
    total++; if (pend_cnt !== 3'd1 || dir !== 2'd3 || key_drop !== 1'b0)
      $display("FAIL up_queued got cnt=%0d dir=%0d drop=%b exp cnt=1 dir=3 drop=0", pend_cnt, dir, key_drop); else passed++;
    tick(1'b0, K_NONE, 1'b1);
    total++; if (dir !== 2'd0 || dir_chg !== 1'b1 || pend_cnt !== 3'd0)
      $display("FAIL up_applied got dir=%0d chg=%b cnt=%0d exp dir=0 chg=1 cnt=0", dir, dir_chg, pend_cnt); else passed++;
    tick(1'b0, K_NONE, 1'b0);
    total++; if (dir !== 2'd0 || dir_chg !== 1'b0)
      $display("FAIL up_chg_single got dir=%0d chg=%b exp dir=0 chg=0", dir, dir_chg); else passed++;
  endtask

  task automatic test_filter;
    tick(1'b1, K_NONE, 1'b0);
    tick(1'b0, K_LT, 1'b0);
    total++; if (key_drop !== 1'b1 || pend_cnt !== 3'd0)
      $display("FAIL drop_opposite got drop=%b cnt=%0d exp drop=1 cnt=0", key_drop, pend_cnt); else passed++;
    tick(1'b0, K_RT, 1'b0);
    total++; if (key_drop !== 1'b1 || pend_cnt !== 3'd0)
      $display("FAIL drop_same got drop=%b cnt=%0d exp drop=1 cnt=0", key_drop, pend_cnt); else passed++;
    tick(1'b0, K_NONE, 1'b0);
    total++; if (key_drop !== 1'b0) $display("FAIL drop_clears got=%b exp=0", key_drop); else passed++;
    tick(1'b0, K_UP, 1'b0);
    tick(1'b0, K_DN, 1'b0);
    total++; if (key_drop !== 1'b1 || pend_cnt !== 3'd1)
      $display("FAIL drop_vs_tail got drop=%b cnt=%0d exp drop=1 cnt=1", key_drop, pend_cnt); else passed++;
  endtask

  task automatic test_sequence;
    tick(1'b1, K_NONE, 1'b0);
    tick(1'b0, K_UP, 1'b0);
    tick(1'b0, K_LT, 1'b0);
    total++; if (pend_cnt !== 3'd2) $display("FAIL seq_cnt got=%0d exp=2", pend_cnt); else passed++;
    tick(1'b0, K_NONE, 1'b1);
    total++; if (dir !== 2'd0 || dir_chg !== 1'b1 || pend_cnt !== 3'd1)
      $display("FAIL seq_step1 got dir=%0d chg=%b cnt=%0d exp dir=0 chg=1 cnt=1", dir, dir_chg, pend_cnt); else passed++;
    tick(1'b0, K_NONE, 1'b1);
    total++; if (dir !== 2'd2 || dir_chg !== 1'b1 || pend_cnt !== 3'd0)
      $display("FAIL seq_step2 got dir=%0d chg=%b cnt=%0d exp dir=2 chg=1 cnt=0", dir, dir_chg, pend_cnt); else passed++;
  endtask

  task automatic test_full;
    tick(1'b1, K_NONE, 1'b0);
    tick(1'b0, K_UP, 1'b0);
    tick(1'b0, K_LT, 1'b0);
    tick(1'b0, K_DN, 1'b1);
    total++; if (pend_cnt !== 3'd2 || dir !== 2'd0 || key_drop !== 1'b0 || dir_chg !== 1'b1)
      $display("FAIL full_push_pop got cnt=%0d dir=%0d drop=%b chg=%b exp cnt=2 dir=0 drop=0 chg=1", pend_cnt, dir, key_drop, dir_chg); else passed++;
    tick(1'b0, K_RT, 1'b0);
    total++; if (key_drop !== 1'b1 || pend_cnt !== 3'd2)
      $display("FAIL full_drop got drop=%b cnt=%0d exp drop=1 cnt=2", key_drop, pend_cnt); else passed++;
    tick(1'b0, K_NONE, 1'b1);
    tick(1'b0, K_NONE, 1'b1);
    total++; if (dir !== 2'd1 || pend_cnt !== 3'd0)
      $display("FAIL full_drain got dir=%0d cnt=%0d exp dir=1 cnt=0", dir, pend_cnt); else passed++;
  endtask

  task automatic test_simultaneous;
    tick(1'b1, K_NONE, 1'b0);
    tick(1'b0, K_UP | K_LT, 1'b0);
    total++; if (pend_cnt !== 3'd1 || key_drop !== 1'b1)
      $display("FAIL simul got cnt=%0d drop=%b exp cnt=1 drop=1", pend_cnt, key_drop); else passed++;
    tick(1'b0, K_NONE, 1'b1);
    total++; if (dir !== 2'd0) $display("FAIL simul_winner got dir=%0d exp=0", dir); else passed++;
  endtask

  task automatic test_key_with_step;
    tick(1'b1, K_NONE, 1'b0);
    tick(1'b0, K_UP, 1'b1);
    total++; if (pend_cnt !== 3'd1 || dir !== 2'd3 || dir_chg !== 1'b0)
      $display("FAIL key_step_empty got cnt=%0d dir=%0d chg=%b exp cnt=1 dir=3 chg=0", pend_cnt, dir, dir_chg); else passed++;
    tick(1'b0, K_NONE, 1'b1);
    total++; if (dir !== 2'd0 || dir_chg !== 1'b1)
      $display("FAIL key_step_next got dir=%0d chg=%b exp dir=0 chg=1", dir, dir_chg); else passed++;
  endtask

  task automatic test_reset_mid;
    tick(1'b1, K_NONE, 1'b0);
    tick(1'b0, K_UP, 1'b0);
    tick(1'b0, K_LT, 1'b0);
    tick(1'b1, K_NONE, 1'b1);
    total++; if (pend_cnt !== 3'd0 || dir !== 2'd3 || dir_chg !== 1'b0)
      $display("FAIL mid_reset got cnt=%0d dir=%0d chg=%b exp cnt=0 dir=3 chg=0", pend_cnt, dir, dir_chg); else passed++;
    tick(1'b0, K_NONE, 1'b1);
    total++; if (dir_chg !== 1'b0 || dir !== 2'd3)
      $display("FAIL mid_reset_step got chg=%b dir=%0d exp chg=0 dir=3", dir_chg, dir); else passed++;
  endtask

  task automatic test_random;
    logic [3:0] k;
    logic s, r;
    int errs;
    tick(1'b1, K_NONE, 1'b0);
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      k = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 79) == 0);
      tick(r, k, s);
      total++;
      if (dir !== mdir || dir_chg !== mchg || key_drop !== mdrop || pend_cnt !== 3'(mq.size())) begin
        if (errs < 10)
          $display("FAIL random_c%0d got dir=%0d chg=%b drop=%b cnt=%0d exp dir=%0d chg=%b drop=%b cnt=%0d",
                   i, dir, dir_chg, key_drop, pend_cnt, mdir, mchg, mdrop, mq.size());
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_single_turn;
    test_filter;
    test_sequence;
    test_full;
    test_simultaneous;
    test_key_with_step;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
